// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, default widths
// and the word-index slice of the byte address.
package dmem_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Only address bits [WORD_MSB:WORD_LSB] select a word in the memory.
  localparam int WORD_LSB = 2;
  localparam int WORD_MSB = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // A word access must have the byte-offset bits clear.
  function automatic logic is_misaligned(input logic [WORD_LSB-1:0] low_bits);
    return low_bits != '0;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to the
// port that was not served last. Purely combinational.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic       grant_valid,
  output logic       grant_id
);

  // Pick the winner from the current requests and the previous grant.
  always_comb begin
    grant_valid = |req;
    grant_id    = 1'b0;
    case (req)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_served;
      default: grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises CPU (port 0) and DMA (port 1) word accesses onto the single-port
// data memory. Each access runs SETUP -> STROBE -> RESP so the address and
// write data are settled before mem_write rises and stay put until it falls.
import dmem_arbiter_pkg::*;

module dmem_arbiter #(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic              busy,
  output logic              grant_id
);

  state_e            state_q;
  logic              last_served_q;
  logic              grant_q;
  logic              we_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              m0_ack_q, m1_ack_q;
  logic              m0_err_q, m1_err_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

  logic [1:0]        arb_req;
  logic              grant_valid;
  logic              grant_sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // During its ack cycle a port's req still belongs to the finished access.
  assign arb_req = {m1_req & ~m1_ack_q, m0_req & ~m0_ack_q};

  rr_arb2 u_arb (
    .req         (arb_req),
    .last_served (last_served_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_sel)
  );

  assign sel_we    = grant_sel ? m1_we    : m0_we;
  assign sel_addr  = grant_sel ? m1_addr  : m0_addr;
  assign sel_wdata = grant_sel ? m1_wdata : m0_wdata;

  // Access sequencer with every memory and requester output held in a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_served_q <= 1'b1;
      grant_q       <= 1'b0;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_q          <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      m0_ack_q      <= 1'b0;
      m1_ack_q      <= 1'b0;
      m0_err_q      <= 1'b0;
      m1_err_q      <= 1'b0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            grant_q <= grant_sel;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            if (ALIGN_CHECK && is_misaligned(sel_addr[WORD_LSB-1:0])) begin
              err_q   <= 1'b1;
              state_q <= ST_RESP;
            end else begin
              err_q      <= 1'b0;
              mem_read_q <= ~sel_we;
              state_q    <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          mem_read_q  <= ~we_q;
          mem_write_q <= we_q;
          state_q     <= ST_STROBE;
        end
        ST_STROBE: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          if (!we_q) begin
            rd_q <= mem_read_data;
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          last_served_q <= grant_q;
          if (grant_q) begin
            m1_ack_q <= 1'b1;
            m1_err_q <= err_q;
            if (!we_q && !err_q) begin
              m1_rdata_q <= rd_q;
            end
          end else begin
            m0_ack_q <= 1'b1;
            m0_err_q <= err_q;
            if (!we_q && !err_q) begin
              m0_rdata_q <= rd_q;
            end
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign m0_ack         = m0_ack_q;
  assign m0_err         = m0_err_q;
  assign m0_rdata       = m0_rdata_q;
  assign m1_ack         = m1_ack_q;
  assign m1_err         = m1_err_q;
  assign m1_rdata       = m1_rdata_q;
  assign busy           = (state_q != ST_IDLE);
  assign grant_id       = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a word memory behind the DUT, a transaction-level
// schedule model compared every cycle, and directed scenarios with literal
// expectations.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int MAXC = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_read, mem_write, busy, grant_id;

  int compared = 0;
  int mismatched = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_read(mem_read), .mem_write(mem_write),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Word memory: commits on the rising edge of mem_write, reads combinationally.
  logic [31:0] tbMem [0:1023];
  int          writeRises;
  logic [31:0] lastWrAddr;
  int          memActivity;

  assign mem_read_data = tbMem[mem_address[WORD_MSB:WORD_LSB]];

  initial begin
    for (int i = 0; i < 1024; i++) tbMem[i] = '0;
    writeRises = 0;
    lastWrAddr = '0;
    forever begin
      @(posedge mem_write);
      tbMem[mem_address[WORD_MSB:WORD_LSB]] = mem_write_data;
      lastWrAddr = mem_address;
      writeRises++;
    end
  end

  initial begin
    memActivity = 0;
    forever begin
      @(posedge clk);
      if (mem_read || mem_write) memActivity++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- schedule model ----------------
  typedef struct {
    bit          busy;
    bit          gid;
    bit          rd;
    bit          wr;
    bit          addrV;
    logic [31:0] addr;
    bit          wdV;
    logic [31:0] wd;
    bit [1:0]    ack;
    bit [1:0]    err;
    bit [1:0]    setRd;
    logic [31:0] rdv0;
    logic [31:0] rdv1;
  } expT;

  expT         expArr [MAXC];
  int          cyc, freeAt, ackPort, ackCycle;
  bit          lastServed;
  bit          pendValid;
  int          pendCycle;
  logic [9:0]  pendIdx;
  logic [31:0] pendData;
  logic [31:0] modelMem [0:1023];
  logic [31:0] curRd0, curRd1;

  task automatic modelReset();
    cyc = 0; freeAt = 1; ackPort = -1; ackCycle = -10;
    lastServed = 1'b1; pendValid = 1'b0;
    curRd0 = '0; curRd1 = '0;
    for (int i = 0; i < MAXC; i++) expArr[i] = '{default: 0};
  endtask

  task automatic modelStep();
    bit r0, r1, we;
    int p, g;
    logic [31:0] addr, wdata;
    cyc++;
    if (pendValid && cyc >= pendCycle) begin
      modelMem[pendIdx] = pendData;
      pendValid = 1'b0;
    end
    if (cyc >= freeAt && cyc + 4 < MAXC) begin
      r0 = m0_req && !(ackPort == 0 && ackCycle == cyc - 1);
      r1 = m1_req && !(ackPort == 1 && ackCycle == cyc - 1);
      if (r0 || r1) begin
        if (r0 && r1) p = lastServed ? 0 : 1;
        else          p = r1 ? 1 : 0;
        we    = (p == 1) ? m1_we : m0_we;
        addr  = (p == 1) ? m1_addr : m0_addr;
        wdata = (p == 1) ? m1_wdata : m0_wdata;
        lastServed = (p == 1);
        g = cyc;
        ackPort = p;
        if (addr[1:0] != 2'b00) begin
          expArr[g].busy = 1; expArr[g].gid = (p == 1);
          expArr[g+1].ack[p] = 1; expArr[g+1].err[p] = 1;
          ackCycle = g + 1; freeAt = g + 2;
        end else begin
          for (int k = 0; k < 3; k++) begin
            expArr[g+k].busy = 1; expArr[g+k].gid = (p == 1);
            expArr[g+k].addrV = 1; expArr[g+k].addr = addr;
            expArr[g+k].wdV = we; expArr[g+k].wd = wdata;
          end
          expArr[g].rd = !we; expArr[g+1].rd = !we; expArr[g+1].wr = we;
          expArr[g+3].ack[p] = 1;
          if (!we) begin
            expArr[g+3].setRd[p] = 1;
            if (p == 1) expArr[g+3].rdv1 = modelMem[addr[11:2]];
            else        expArr[g+3].rdv0 = modelMem[addr[11:2]];
          end else begin
            pendValid = 1; pendCycle = g + 1; pendIdx = addr[11:2]; pendData = wdata;
          end
          ackCycle = g + 3; freeAt = g + 4;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) modelMem[i] = '0;
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else        modelStep();
    end
  end

  // Per-cycle compare against the model (or the all-zero reset state).
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_mem_read", mem_read, 0);
        checkOutput("rst_mem_write", mem_write, 0);
        checkOutput("rst_mem_address", mem_address, 0);
        checkOutput("rst_acks", {m1_ack, m0_ack}, 0);
        checkOutput("rst_errs", {m1_err, m0_err}, 0);
        checkOutput("rst_m0_rdata", m0_rdata, 0);
        checkOutput("rst_m1_rdata", m1_rdata, 0);
      end else if (cyc < MAXC) begin
        e = expArr[cyc];
        if (e.setRd[0]) curRd0 = e.rdv0;
        if (e.setRd[1]) curRd1 = e.rdv1;
        checkOutput("cyc_busy", busy, e.busy);
        checkOutput("cyc_mem_read", mem_read, e.rd);
        checkOutput("cyc_mem_write", mem_write, e.wr);
        checkOutput("cyc_m0_ack", m0_ack, e.ack[0]);
        checkOutput("cyc_m1_ack", m1_ack, e.ack[1]);
        checkOutput("cyc_m0_err", m0_err, e.err[0]);
        checkOutput("cyc_m1_err", m1_err, e.err[1]);
        checkOutput("cyc_m0_rdata", m0_rdata, curRd0);
        checkOutput("cyc_m1_rdata", m1_rdata, curRd1);
        if (e.busy)  checkOutput("cyc_grant_id", grant_id, e.gid);
        if (e.addrV) checkOutput("cyc_mem_address", mem_address, e.addr);
        if (e.wdV)   checkOutput("cyc_mem_write_data", mem_write_data, e.wd);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic driveReq(input int port, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
    else           begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
  endtask

  task automatic dropReq(input int port);
    if (port == 0) m0_req = 0;
    else           m1_req = 0;
  endtask

  task automatic applyStimulus(input int port, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    driveReq(port, we, addr, wdata);
  endtask

  task automatic waitAck(input int port, output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((port == 0 && m0_ack) || (port == 1 && m1_ack)) begin
        lat = i;
        break;
      end
    end
    checkOutput("ack_seen", (lat != 0), 1);
    dropReq(port);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int lat, lat0, lat1, n, cnt, base;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_mem_write", mem_write, 0);

    $display("[TB] single write then read");
    base = writeRises;
    applyStimulus(0, 1'b1, 32'h10, 32'hCAFEF00D);
    waitAck(0, lat);
    checkOutput("t1_wr_latency", lat, 4);
    checkOutput("t1_wr_rises", writeRises - base, 1);
    checkOutput("t1_wr_addr", lastWrAddr, 32'h10);
    checkOutput("t1_mem_word", tbMem[4], 32'hCAFEF00D);
    applyStimulus(0, 1'b0, 32'h10, 32'h0);
    waitAck(0, lat);
    checkOutput("t1_rd_latency", lat, 4);
    checkOutput("t1_rd_data", m0_rdata, 32'hCAFEF00D);

    $display("[TB] misaligned read on port 1");
    base = memActivity;
    applyStimulus(1, 1'b0, 32'h6, 32'h0);
    waitAck(1, lat);
    checkOutput("t3_err_latency", lat, 2);
    checkOutput("t3_err_flag", m1_err, 1);
    checkOutput("t3_rdata_kept", m1_rdata, 0);
    checkOutput("t3_no_mem_activity", memActivity - base, 0);

    $display("[TB] tie arbitration");
    @(negedge clk);
    driveReq(0, 1'b0, 32'h10, 32'h0);
    driveReq(1, 1'b1, 32'h30, 32'hA5A50001);
    n = 0;
    for (int i = 1; i <= 40 && n < 4; i++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        checkOutput("t2_one_ack", m0_ack & m1_ack, 0);
        checkOutput("t2_ack_port", m1_ack, n % 2);
        checkOutput("t2_ack_time", i, 4 * (n + 1));
        n++;
      end
    end
    checkOutput("t2_ack_count", n, 4);
    dropReq(0); dropReq(1);

    $display("[TB] busy hold-off");
    applyStimulus(0, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    driveReq(1, 1'b0, 32'h30, 32'h0);
    lat0 = 0; lat1 = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 4) checkOutput("t4_grant_m1", {busy, grant_id}, 2'b11);
      if (m0_ack && lat0 == 0) begin lat0 = i; dropReq(0); end
      if (m1_ack) begin
        lat1 = i;
        checkOutput("t4_m0_rdata_hold", m0_rdata, 32'hCAFEF00D);
        checkOutput("t4_m1_rdata", m1_rdata, 32'hA5A50001);
        dropReq(1);
        break;
      end
    end
    checkOutput("t4_m0_latency", lat0, 3);
    checkOutput("t4_m1_latency", lat1, 7);

    $display("[TB] early drop");
    applyStimulus(0, 1'b1, 32'h40, 32'hDEADBEEF);
    @(negedge clk);
    dropReq(0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (m0_ack) cnt++;
    end
    checkOutput("t6_ack_pulses", cnt, 1);
    checkOutput("t6_mem_word", tbMem[16], 32'hDEADBEEF);

    $display("[TB] reset during strobe");
    applyStimulus(0, 1'b1, 32'h20, 32'h12345678);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5_in_strobe", mem_write, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_mem_write", mem_write, 0);
    checkOutput("t5_rst_busy", busy, 0);
    checkOutput("t5_rst_address", mem_address, 0);
    dropReq(0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (m0_ack) cnt++;
    end
    checkOutput("t5_no_ack", cnt, 0);
    #2 rst_n = 1'b1;
    checkOutput("t5_committed", tbMem[8], 32'h12345678);
    @(negedge clk);
    driveReq(0, 1'b0, 32'h20, 32'h0);
    driveReq(1, 1'b0, 32'h10, 32'h0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin lat = i; break; end
    end
    checkOutput("t5_first_tie_port", {m1_ack, m0_ack}, 2'b01);
    checkOutput("t5_first_latency", lat, 4);
    checkOutput("t5_read_back", m0_rdata, 32'h12345678);
    dropReq(0);
    waitAck(1, lat);
    checkOutput("t5_second_latency", lat, 4);
    checkOutput("t5_m1_read", m1_rdata, 32'hCAFEF00D);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
